// File: rtl/adder_axis_pkg.sv
// Shared definitions for the adder_axis_split block: AXI-Stream width
// derivation and the width of the optional statistics counters.
package adder_axis_pkg;

    // Width of the statistics counters (wrap modulo 2^16)
    localparam int STATS_W = 16;

    // AXI-Stream tdata width: operand sum (ADDER_WIDTH+1 bits) rounded up to whole bytes
    function automatic int axis_width_f(input int adder_width);
        return 8 * ((adder_width + 8) / 8);
    endfunction

endpackage

// File: rtl/adder_axis_split_fifo.sv
// axis_fifo2: two-entry FIFO kept as a head/tail register pair so the head
// register drives the stream output directly. Push is ignored when full and
// pop is ignored when empty; simultaneous push/pop keeps occupancy and order.
module axis_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push_s;
    logic             pop_s;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign data_o  = head_q;
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;

    // Next-state of occupancy and head/tail storage for each push/pop combination
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push_s, pop_s})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end else begin
                    head_d = head_q;
                end
            end
            2'b11: begin
                // Only reachable with one entry: the new word becomes the head
                if (count_q == 2'd1) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State registers; reset empties the FIFO and zeroes the output word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/adder_axis_split.sv
// adder_axis_split: splits an input sum S into two addends (ceil/floor halves,
// saturating at the all-ones sum) and streams each on its own AXI-Stream port
// through an independent 2-entry FIFO.
// Optional feature: define ADDER_SPLIT_STATS_EN to add split_cnt_o/sat_cnt_o.
module adder_axis_split
    import adder_axis_pkg::*;
#(
    parameter  int ADDER_WIDTH = 8,
    localparam int AXIS_WIDTH  = axis_width_f(ADDER_WIDTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [AXIS_WIDTH-1:0] data_i_tdata,
    input  logic                  data_i_tvalid,
    output logic                  data_i_tready,
    output logic [AXIS_WIDTH-1:0] data1_o_tdata,
    output logic                  data1_o_tvalid,
    input  logic                  data1_o_tready,
    output logic [AXIS_WIDTH-1:0] data2_o_tdata,
    output logic                  data2_o_tvalid,
    input  logic                  data2_o_tready
`ifdef ADDER_SPLIT_STATS_EN
    ,
    output logic [STATS_W-1:0]    split_cnt_o,
    output logic [STATS_W-1:0]    sat_cnt_o
`endif
);

    logic [ADDER_WIDTH:0]   sum_s;
    logic [ADDER_WIDTH-1:0] half_s;
    logic [ADDER_WIDTH-1:0] d1_s;
    logic [AXIS_WIDTH-1:0]  d1_ext_s;
    logic [AXIS_WIDTH-1:0]  d2_ext_s;
    logic                   sat_s;
    logic                   push_s;
    logic                   full1_s, full2_s;
    logic                   empty1_s, empty2_s;
    logic                   running_q;

    assign sum_s  = data_i_tdata[ADDER_WIDTH:0];
    assign sat_s  = &sum_s;
    assign half_s = sum_s[ADDER_WIDTH:1];

    generate
        if (AXIS_WIDTH > ADDER_WIDTH + 1) begin : g_pad
            logic unused_pad_s;
            assign unused_pad_s = ^data_i_tdata[AXIS_WIDTH-1:ADDER_WIDTH+1];
        end
    endgenerate

    // First addend is the ceiling half; it only overflows for the all-ones sum, where it saturates
    always_comb begin
        if (sat_s) begin
            d1_s = '1;
        end else begin
            d1_s = half_s + {{(ADDER_WIDTH-1){1'b0}}, sum_s[0]};
        end
    end

    assign d1_ext_s = {{(AXIS_WIDTH-ADDER_WIDTH){1'b0}}, d1_s};
    assign d2_ext_s = {{(AXIS_WIDTH-ADDER_WIDTH){1'b0}}, half_s};

    // Ready depends only on registered state, never on the output readies
    assign data_i_tready  = running_q & ~full1_s & ~full2_s;
    assign push_s         = data_i_tvalid & data_i_tready;
    assign data1_o_tvalid = ~empty1_s;
    assign data2_o_tvalid = ~empty2_s;

    // Holds input ready low during reset and for the release edge
    always_ff @(posedge aclk) begin
        if (areset) begin
            running_q <= 1'b0;
        end else begin
            running_q <= 1'b1;
        end
    end

    axis_fifo2 #(.WIDTH(AXIS_WIDTH)) u_fifo1 (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (push_s),
        .data_i  (d1_ext_s),
        .pop_i   (data1_o_tready),
        .data_o  (data1_o_tdata),
        .full_o  (full1_s),
        .empty_o (empty1_s)
    );

    axis_fifo2 #(.WIDTH(AXIS_WIDTH)) u_fifo2 (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (push_s),
        .data_i  (d2_ext_s),
        .pop_i   (data2_o_tready),
        .data_o  (data2_o_tdata),
        .full_o  (full2_s),
        .empty_o (empty2_s)
    );

`ifdef ADDER_SPLIT_STATS_EN
    logic [STATS_W-1:0] split_cnt_q;
    logic [STATS_W-1:0] sat_cnt_q;

    assign split_cnt_o = split_cnt_q;
    assign sat_cnt_o   = sat_cnt_q;

    // Count accepted words and saturated splits, wrapping naturally
    always_ff @(posedge aclk) begin
        if (areset) begin
            split_cnt_q <= '0;
            sat_cnt_q   <= '0;
        end else if (push_s) begin
            split_cnt_q <= split_cnt_q + {{(STATS_W-1){1'b0}}, 1'b1};
            sat_cnt_q   <= sat_cnt_q + {{(STATS_W-1){1'b0}}, sat_s};
        end else begin
            split_cnt_q <= split_cnt_q;
            sat_cnt_q   <= sat_cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_adder_axis_split.sv
// Self-checking bench for adder_axis_split (ADDER_WIDTH=8). A negedge monitor
// keeps per-output scoreboards of expected addends pushed on each input
// handshake; scenario tasks add directed checks.
module tb_adder_axis_split;

    localparam int AW = 8;
    localparam int XW = 16;

    logic          aclk;
    logic          areset;
    logic [XW-1:0] data_i_tdata;
    logic          data_i_tvalid;
    logic          data_i_tready;
    logic [XW-1:0] data1_o_tdata;
    logic          data1_o_tvalid;
    logic          data1_o_tready;
    logic [XW-1:0] data2_o_tdata;
    logic          data2_o_tvalid;
    logic          data2_o_tready;
`ifdef ADDER_SPLIT_STATS_EN
    logic [15:0]   split_cnt_o;
    logic [15:0]   sat_cnt_o;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int in_acc = 0;
    int out1_cnt = 0;
    int out2_cnt = 0;
    logic [XW-1:0] q1[$];
    logic [XW-1:0] q2[$];
    bit            st1 = 1'b0;
    bit            st2 = 1'b0;
    logic [XW-1:0] sd1;
    logic [XW-1:0] sd2;

    adder_axis_split #(.ADDER_WIDTH(AW)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .data_i_tdata   (data_i_tdata),
        .data_i_tvalid  (data_i_tvalid),
        .data_i_tready  (data_i_tready),
        .data1_o_tdata  (data1_o_tdata),
        .data1_o_tvalid (data1_o_tvalid),
        .data1_o_tready (data1_o_tready),
        .data2_o_tdata  (data2_o_tdata),
        .data2_o_tvalid (data2_o_tvalid),
        .data2_o_tready (data2_o_tready)
`ifdef ADDER_SPLIT_STATS_EN
        ,
        .split_cnt_o    (split_cnt_o),
        .sat_cnt_o      (sat_cnt_o)
`endif
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Reference split: ceil half / floor half, each capped at 2^AW-1
    function automatic logic [XW-1:0] exp_d1(input int s);
        int v;
        v = s - (s / 2);
        if (v > 255) v = 255;
        return XW'(v);
    endfunction

    function automatic logic [XW-1:0] exp_d2(input int s);
        int v;
        v = s / 2;
        if (v > 255) v = 255;
        return XW'(v);
    endfunction

    // Scoreboard monitor: samples handshakes half a cycle before the edge that completes them
    initial begin
        forever begin
            @(negedge aclk);
            if (areset) begin
                q1.delete();
                q2.delete();
                st1 = 1'b0;
                st2 = 1'b0;
            end else begin
                if (st1) begin
                    n_cmp++;
                    if (!data1_o_tvalid || data1_o_tdata !== sd1) begin
                        n_fail++;
                        $display("FAIL d1_stable: got v=%0b d=%0d required v=1 d=%0d", data1_o_tvalid, data1_o_tdata, sd1);
                    end
                end
                if (st2) begin
                    n_cmp++;
                    if (!data2_o_tvalid || data2_o_tdata !== sd2) begin
                        n_fail++;
                        $display("FAIL d2_stable: got v=%0b d=%0d required v=1 d=%0d", data2_o_tvalid, data2_o_tdata, sd2);
                    end
                end
                st1 = data1_o_tvalid && !data1_o_tready;
                sd1 = data1_o_tdata;
                st2 = data2_o_tvalid && !data2_o_tready;
                sd2 = data2_o_tdata;
                if (data_i_tvalid && data_i_tready) begin
                    q1.push_back(exp_d1(int'(data_i_tdata[AW:0])));
                    q2.push_back(exp_d2(int'(data_i_tdata[AW:0])));
                    in_acc++;
                end
                if (data1_o_tvalid && data1_o_tready) begin
                    n_cmp++;
                    out1_cnt++;
                    if (q1.size() == 0) begin
                        n_fail++;
                        $display("FAIL d1_unexpected: got %0d required no word", data1_o_tdata);
                    end else begin
                        logic [XW-1:0] e;
                        e = q1.pop_front();
                        if (data1_o_tdata !== e) begin
                            n_fail++;
                            $display("FAIL d1_data: got %0d required %0d", data1_o_tdata, e);
                        end
                    end
                end
                if (data2_o_tvalid && data2_o_tready) begin
                    n_cmp++;
                    out2_cnt++;
                    if (q2.size() == 0) begin
                        n_fail++;
                        $display("FAIL d2_unexpected: got %0d required no word", data2_o_tdata);
                    end else begin
                        logic [XW-1:0] e;
                        e = q2.pop_front();
                        if (data2_o_tdata !== e) begin
                            n_fail++;
                            $display("FAIL d2_data: got %0d required %0d", data2_o_tdata, e);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Offer one word and hold it until accepted or the wait budget runs out
    task automatic send(input int s, input int maxwait);
        bit done;
        done = 1'b0;
        data_i_tdata  = XW'(s);
        data_i_tvalid = 1'b1;
        for (int k = 0; k < maxwait && !done; k++) begin
            @(negedge aclk);
            if (data_i_tready) done = 1'b1;
            @(posedge aclk);
            #1;
        end
        data_i_tvalid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: word %0d not accepted within %0d cycles", s, maxwait);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick(3);
        n_cmp++;
        if (data_i_tready !== 1'b0 || data1_o_tvalid !== 1'b0 || data2_o_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy=%0b v1=%0b v2=%0b required 0 0 0", data_i_tready, data1_o_tvalid, data2_o_tvalid);
        end
        n_cmp++;
        if (data1_o_tdata !== 16'd0 || data2_o_tdata !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d/%0d required 0/0", data1_o_tdata, data2_o_tdata);
        end
        areset = 1'b0;
        n_cmp++;
        if (data_i_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_early: got rdy=%0b required 0", data_i_tready);
        end
        tick(1);
        n_cmp++;
        if (data_i_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got rdy=%0b required 1", data_i_tready);
        end
    endtask

    task automatic test_latency();
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b1;
        send(9, 4);
        n_cmp++;
        if (data1_o_tvalid !== 1'b1 || data1_o_tdata !== 16'd5 || data2_o_tvalid !== 1'b1 || data2_o_tdata !== 16'd4) begin
            n_fail++;
            $display("FAIL latency_9: got v1=%0b d1=%0d v2=%0b d2=%0d required 1 5 1 4",
                     data1_o_tvalid, data1_o_tdata, data2_o_tvalid, data2_o_tdata);
        end
        tick(1);
        n_cmp++;
        if (data1_o_tvalid !== 1'b0 || data2_o_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_drain: got v1=%0b v2=%0b required 0 0", data1_o_tvalid, data2_o_tvalid);
        end
    endtask

    task automatic test_boundary();
        send(510, 4);
        send(511, 4);
        n_cmp++;
        if (data1_o_tdata !== 16'd255 || data2_o_tdata !== 16'd255) begin
            n_fail++;
            $display("FAIL sat_511: got %0d/%0d required 255/255", data1_o_tdata, data2_o_tdata);
        end
        tick(3);
`ifdef ADDER_SPLIT_STATS_EN
        n_cmp++;
        if (sat_cnt_o !== 16'd1 || split_cnt_o !== 16'd3) begin
            n_fail++;
            $display("FAIL stats_boundary: got sat=%0d split=%0d required 1 3", sat_cnt_o, split_cnt_o);
        end
`endif
    endtask

    task automatic test_backpressure();
        int base, o1, o2;
        base = in_acc;
        o1 = out1_cnt;
        o2 = out2_cnt;
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b0;
        send(2, 4);
        send(4, 4);
        data_i_tdata  = 16'd6;
        data_i_tvalid = 1'b1;
        tick(6);
        n_cmp++;
        if (in_acc - base != 2 || data_i_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: got accepted=%0d rdy=%0b required 2 0", in_acc - base, data_i_tready);
        end
        n_cmp++;
        if (out1_cnt - o1 != 2 || data2_o_tvalid !== 1'b1 || data2_o_tdata !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_state: got out1=%0d v2=%0b d2=%0d required 2 1 1", out1_cnt - o1, data2_o_tvalid, data2_o_tdata);
        end
        data2_o_tready = 1'b1;
        send(6, 20);
        tick(3);
        n_cmp++;
        if (out1_cnt - o1 != 3 || out2_cnt - o2 != 3) begin
            n_fail++;
            $display("FAIL bp_drain: got out1=%0d out2=%0d required 3 3", out1_cnt - o1, out2_cnt - o2);
        end
    endtask

    task automatic test_random();
        int base, o1, o2;
        bit done;
        base = in_acc;
        o1 = out1_cnt;
        o2 = out2_cnt;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int s;
                    tick($urandom_range(0, 3));
                    s = (i % 50 == 0) ? 511 : int'($urandom_range(0, 511));
                    send(s, 200);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    data1_o_tready = ($urandom_range(0, 3) != 0);
                    data2_o_tready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            end
        join
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b1;
        for (int k = 0; k < 20 && (q1.size() != 0 || q2.size() != 0); k++) tick(1);
        n_cmp++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d/%0d pending required 0/0", q1.size(), q2.size());
        end
        n_cmp++;
        if (in_acc - base != 1000 || out1_cnt - o1 != 1000 || out2_cnt - o2 != 1000) begin
            n_fail++;
            $display("FAIL rand_counts: got in=%0d o1=%0d o2=%0d required 1000 each", in_acc - base, out1_cnt - o1, out2_cnt - o2);
        end
    endtask

    task automatic test_reset_mid();
        data1_o_tready = 1'b0;
        data2_o_tready = 1'b0;
        send(7, 4);
        send(8, 4);
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
        n_cmp++;
        if (data1_o_tvalid !== 1'b0 || data2_o_tvalid !== 1'b0 || data_i_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flags: got v1=%0b v2=%0b rdy=%0b required 0 0 0", data1_o_tvalid, data2_o_tvalid, data_i_tready);
        end
`ifdef ADDER_SPLIT_STATS_EN
        n_cmp++;
        if (split_cnt_o !== 16'd0 || sat_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_stats: got %0d/%0d required 0/0", split_cnt_o, sat_cnt_o);
        end
`endif
        tick(1);
        n_cmp++;
        if (data_i_tready !== 1'b1 || data1_o_tvalid !== 1'b0 || data2_o_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after: got rdy=%0b v1=%0b v2=%0b required 1 0 0", data_i_tready, data1_o_tvalid, data2_o_tvalid);
        end
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b1;
        send(20, 4);
        n_cmp++;
        if (data1_o_tvalid !== 1'b1 || data1_o_tdata !== 16'd10 || data2_o_tdata !== 16'd10) begin
            n_fail++;
            $display("FAIL midrst_new: got v1=%0b d1=%0d d2=%0d required 1 10 10", data1_o_tvalid, data1_o_tdata, data2_o_tdata);
        end
        tick(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset         = 1'b1;
        data_i_tdata   = 16'd0;
        data_i_tvalid  = 1'b0;
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b1;
        #1;
        test_reset();
        test_latency();
        test_boundary();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_axis_split.md
ADDER_AXIS_SPLIT -- requirements
Module: adder_axis_split

Interface
REQ-001 Parameter ADDER_WIDTH, default 8: operand width; input sum carries ADDER_WIDTH+1 significant bits.
REQ-002 Local constant AXIS_WIDTH, fixed at 8*((ADDER_WIDTH+8)/8), default 16: tdata width of every port, byte-padded.
REQ-003 aclk  in  1  single clock; all state updates on rising edge.
REQ-004 areset  in  1  synchronous, active-high reset.
REQ-005 data_i_tdata  in  AXIS_WIDTH  sum S in bits [ADDER_WIDTH:0]; upper bits ignored.
REQ-006 data_i_tvalid  in  1 / data_i_tready  out  1  input stream handshake.
REQ-007 data1_o_tdata  out  AXIS_WIDTH  first addend, zero-extended.
REQ-008 data1_o_tvalid  out  1 / data1_o_tready  in  1  first output handshake.
REQ-009 data2_o_tdata  out  AXIS_WIDTH  second addend, zero-extended.
REQ-010 data2_o_tvalid  out  1 / data2_o_tready  in  1  second output handshake.

Function
REQ-011 Split rule: data2 = S>>1 (floor), data1 = S - data2 (ceil), so data1+data2 = S for every S <= 2^(ADDER_WIDTH+1)-2.
REQ-012 Boundary S = 2^(ADDER_WIDTH+1)-1: data1 and data2 both saturate to 2^ADDER_WIDTH-1; the word is still emitted.
REQ-013 Each output owns an independent 2-entry FIFO; an input handshake writes the split result into both FIFOs in the same cycle.
REQ-014 data_i_tready = neither FIFO full; derived from registered occupancy only, no combinational path from any data*_o_tready.
REQ-015 dataN_o_tvalid = FIFO N non-empty; dataN_o_tdata = FIFO N head; pop on dataN_o_tvalid && dataN_o_tready.
REQ-016 Latency: word accepted at edge k is valid on both outputs after edge k (1 cycle) when the FIFOs were empty.
REQ-017 Simultaneous push and pop on a FIFO: occupancy unchanged, order kept; throughput 1 word/cycle with both readies high.
REQ-018 Outputs drain independently; either output may lead the other by up to 2 words; each output preserves input order.
REQ-019 Once asserted, dataN_o_tvalid and dataN_o_tdata stay stable until the handshake completes.
REQ-020 FIFO full (2 entries) on either side: data_i_tready low; a held data_i_tvalid/tdata is accepted when space frees.

Reset
REQ-021 While areset is high, data_i_tready, data1_o_tvalid, data2_o_tvalid are 0 and both tdata outputs are 0 from the next edge.
REQ-022 Reset mid-operation discards all buffered words; FIFO occupancies become 0; no stale word appears after release.
REQ-023 data_i_tready rises the first cycle after areset falls.

Configuration
REQ-024 Macro ADDER_SPLIT_STATS_EN defined: adds ports split_cnt_o (out, 16) counting accepted input words and sat_cnt_o (out, 16) counting REQ-012 saturations; both wrap modulo 2^16 and reset to 0.
REQ-025 Macro undefined: neither port nor counter exists; all other behaviour is identical.

Structure
REQ-026 Package adder_axis_pkg holds the AXIS_WIDTH derivation function and the statistics counter width (16).
REQ-027 Sub-module axis_fifo2 (2-entry, parameterised width, full/empty flags) is instantiated once per output.

Verification
REQ-028 ADDER_WIDTH=8, S=9, both readies high -> data1=5, data2=4, one cycle after the input handshake.
REQ-029 S=510 -> 255/255; S=511 -> 255/255 and sat_cnt_o increments to 1 (with STATS_EN).
REQ-030 data1_o_tready=1, data2_o_tready=0, inputs S=2,4,6 back-to-back -> only 2 words accepted; data1 emits 1,2; data_i_tready stays low until data2_o_tready rises, then data2 emits 1,2, then 6 is split to 3/3.
REQ-031 1000 random S with random delays on all three interfaces -> every output pair sums to its S in order; no watchdog timeout.
REQ-032 Two words buffered, areset pulsed 1 cycle -> both tvalids 0 next cycle, counters 0, first post-reset output pair comes from a new input.
